// File: rtl/encoder_pkg.sv
// Shared types and constants for the serial 8-to-3 encoder.
package encoder_pkg;

  localparam int N_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int vec_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder: index of the lowest 1 plus an any-set flag.
module lsb_prio_enc
  import encoder_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [vec_width(N)-1:0] vec,
  output logic [N-1:0]            idx,
  output logic                    any
);

  localparam int V = vec_width(N);

  // Scan from the top down so the lowest set bit wins the final assignment.
  always_comb begin
    idx = '0;
    for (int i = V - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[N-1:0];
    end
  end

  assign any = |vec;

endmodule

// File: rtl/encoder8x3_serial.sv
// Serialises each set bit of a captured vector into ascending binary indices over a valid/ready stream.
// Optional ENCODER_POPCOUNT_EN adds a registered set-bit count of each captured vector.
module encoder8x3_serial
  import encoder_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [vec_width(N)-1:0] in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out,
  output logic                    out_last
`ifdef ENCODER_POPCOUNT_EN
  ,
  output logic [N:0]              count
`endif
);

  localparam int V = vec_width(N);
  localparam logic [V-1:0] ONE = {{(V-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [V-1:0]   pending_q, pending_d;
  logic [V-1:0]   pending_rest;
  logic [N-1:0]   lsb_idx;
  logic           lsb_any;
  logic           single;
  logic           capture;
  logic           beat;

  lsb_prio_enc #(.N(N)) u_lsb (
    .vec (pending_q),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  // Clearing the lowest set bit leaves what remains after the current beat.
  assign pending_rest = pending_q & (pending_q - ONE);
  assign single       = lsb_any && (pending_rest == '0);

  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && single;
  assign out       = out_valid ? lsb_idx : '0;

  assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
  assign capture   = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (beat) begin
      pending_d = pending_rest;
      if (single) state_d = IDLE;
    end
    if (capture) begin
      pending_d = in;
      state_d   = (in != '0) ? EMIT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef ENCODER_POPCOUNT_EN
  logic [N:0] count_q, count_d;

  function automatic logic [N:0] popcount(input logic [V-1:0] v);
    logic [N:0] c;
    c = '0;
    for (int i = 0; i < V; i++) c = c + {{N{1'b0}}, v[i]};
    return c;
  endfunction

  always_comb begin
    count_d = count_q;
    if (capture) count_d = popcount(in);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_encoder8x3_serial.sv
// Directed bench for encoder8x3_serial; expected beats are hand-derived from each input vector.
module tb_encoder8x3_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out;
  logic       out_last;
`ifdef ENCODER_POPCOUNT_EN
  logic [3:0] count;
`endif

  int checks;
  int errors;

  encoder8x3_serial #(.N(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_last  (out_last)
`ifdef ENCODER_POPCOUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input int idx, input int last);
    chk({tag, "_vld"}, int'(out_valid), 1);
    chk({tag, "_out"}, int'(out), idx);
    chk({tag, "_last"}, int'(out_last), last);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_vld"}, int'(out_valid), 0);
    chk({tag, "_out"}, int'(out), 0);
    chk({tag, "_last"}, int'(out_last), 0);
    chk({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in        = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    expect_idle("rst");
`ifdef ENCODER_POPCOUNT_EN
    chk("rst_count", int'(count), 0);
`endif

    // 0xA4 -> 2, 5, 7(last)
    in = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
    chk("a4_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    expect_beat("a4_b0", 2, 0);
    tick();
    expect_beat("a4_b1", 5, 0);
    tick();
    expect_beat("a4_b2", 7, 1);
    chk("a4_b2_rdy", int'(in_ready), 1);
    tick();
    expect_idle("a4_end");

    // all-zero vector consumed silently
    in = 8'h00; in_valid = 1'b1;
    chk("zero_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) chk("zero_vld", int'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      chk("zero_hold_vld", int'(out_valid), 0);
      tick();
    end

    // 0x18 with downstream stalled; a competing vector must not be captured
    in = 8'b0001_1000; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      expect_beat("stall", 3, 0);
      chk("stall_rdy", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    expect_beat("s18_b0", 3, 0);
    tick();
    expect_beat("s18_b1", 4, 1);
    tick();
    expect_idle("s18_end");

    // back-to-back: 0x80 then 0x01 captured on the final beat
    in = 8'h80; in_valid = 1'b1;
    tick();
    in = 8'h01;
    expect_beat("b2b_b0", 7, 1);
    chk("b2b_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    expect_beat("b2b_b1", 0, 1);
    tick();
    expect_idle("b2b_end");

    // zero vector captured on a final beat returns to IDLE
    in = 8'h02; in_valid = 1'b1;
    tick();
    in = 8'h00;
    expect_beat("b2z_b0", 1, 1);
    tick();
    in_valid = 1'b0;
    expect_idle("b2z_end");
    tick();
    expect_idle("b2z_end2");

    // reset mid-EMIT after beats 0 and 1
    in = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_beat("rstm_b0", 0, 0);
    tick();
    expect_beat("rstm_b1", 1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_idle("rstm_after");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstm_quiet", int'(out_valid), 0);
    end

`ifdef ENCODER_POPCOUNT_EN
    in = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pc_ff", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      expect_beat("pc_beat", i, (i == 7) ? 1 : 0);
      tick();
    end
    chk("pc_ff_hold", int'(count), 8);
    in = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pc_11", int'(count), 2);
    expect_beat("pc11_b0", 0, 0);
    tick();
    expect_beat("pc11_b1", 4, 1);
    tick();
    expect_idle("pc11_end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder8x3_serial.md
ENCODER8X3_SERIAL -- requirements
Module: encoder8x3_serial

Interface
REQ-001 Parameter N SHALL default to 3; it sets the index width, and the input vector SHALL be 2**N bits wide.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL flag that the upstream vector `in` is valid.
REQ-005 in_ready  output  1  SHALL flag that the block can capture `in` this cycle.
REQ-006 in  input  2**N  SHALL carry the request vector; each set bit is one index to emit.
REQ-007 out_valid  output  1  SHALL flag that `out` holds a valid index.
REQ-008 out_ready  input  1  SHALL flag that downstream accepts `out` this cycle.
REQ-009 out  output  N  SHALL carry the binary index of the lowest pending set bit.
REQ-010 out_last  output  1  SHALL flag that the current `out` is the final index of the captured vector.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and EMIT.
REQ-012 A vector SHALL be captured only on a cycle where in_valid and in_ready are both high.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-014 A captured nonzero vector SHALL load the pending register and move to EMIT; out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-015 A captured all-zero vector SHALL be consumed silently, with the block staying in IDLE and emitting no beat.
REQ-016 In EMIT, out_valid SHALL be 1, `out` SHALL be the index of the lowest set bit of pending, and out_last SHALL be 1 exactly when pending has one bit set.
REQ-017 On each accepted beat (out_valid and out_ready), the emitted bit SHALL be cleared from pending.
REQ-018 An accepted beat with out_last=1 SHALL return the FSM to IDLE, unless REQ-020 applies.
REQ-019 While out_valid is high and out_ready is low, out and out_last SHALL hold stable.
REQ-020 in_ready SHALL equal (state==IDLE) or (state==EMIT and out_last and out_ready).
- A same-cycle capture on the final beat SHALL load the new vector and stay in EMIT, or go to IDLE if that vector is zero.
- This gives zero bubble cycles between back-to-back vectors.
REQ-021 When out_valid is 0, out and out_last SHALL be driven to 0.
REQ-022 Indices SHALL be emitted in strictly ascending order, one per accepted beat, never repeating and never skipping a set bit.

Reset
REQ-023 While rst_n is low at a clock edge, the block SHALL go to state=IDLE with pending=0, out_valid=0, out=0, out_last=0 and in_ready=1 after that edge.
REQ-024 A reset asserted mid-EMIT SHALL discard all remaining pending indices with no further beats.

Configuration
REQ-025 With macro ENCODER_POPCOUNT_EN defined, the block SHALL add output `count` (output, N+1 bits).
- `count` SHALL be registered on each capture as the number of set bits in `in`.
- `count` SHALL hold until the next capture and SHALL reset to 0.
REQ-026 Without ENCODER_POPCOUNT_EN, the `count` port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package encoder_pkg SHALL hold:
- the default N constant;
- the state enum type {IDLE, EMIT};
- a function returning the vector width 2**N.
REQ-028 Lowest-set-bit search SHALL live in a combinational sub-module, lsb_prio_enc.
- Input: the pending vector.
- Outputs: the index and an any-set flag.
REQ-029 The top level SHALL contain only the FSM, the pending register, the handshake logic and the optional popcount.

Verification
REQ-030 in=8'b1010_0100 with out_ready=1 -> out=2,5,7 on three consecutive cycles; out_last=1 only on 7; IDLE after.
REQ-031 in=8'h00 with in_valid=1 -> accepted (in_ready=1) and out_valid stays 0 for 5 cycles.
REQ-032 in=8'b0001_1000 with out_ready=0 for 3 cycles -> out=3 held valid for 3 cycles; then 3,4 emitted once out_ready=1.
REQ-033 Back-to-back: on the accepted final beat of in=8'h80, present in=8'h01 -> out=7 (last), then out=0 (last) on the very next cycle, with no bubble.
REQ-034 Reset mid-operation: in=8'hFF, rst_n low after 2 beats (0,1) -> next cycle out_valid=0, in_ready=1, no further beats.
REQ-035 With ENCODER_POPCOUNT_EN: in=8'hFF -> count=8 and beats 0..7 with out_last on 7; then in=8'h11 -> count=2.
